// File: rtl/rle_mask_encoder.sv
// Run-length encoder for binary pixel masks: turns one mask bit per pixel into
// alternating-symbol run words delivered through a small first-word-fall-through queue.
module rle_mask_encoder #(
    parameter int unsigned WIDTH      = 13,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned FRAMECNT_W = 16
) (
    input  logic                  CLK,
    input  logic                  reset_n,
    input  logic                  pix_valid,
    output logic                  pix_ready,
    input  logic                  pix_data,
    input  logic                  pix_sof,
    input  logic                  pix_eof,
    output logic                  run_valid,
    input  logic                  run_ready,
    output logic [WIDTH-1:0]      run_len,
    output logic                  run_symbol,
    output logic                  run_last,
    output logic [FRAMECNT_W-1:0] frame_runs,
    output logic                  frame_abort
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned WORD_W = WIDTH + 2;

    localparam logic [WIDTH-1:0] MaxRun   = '1;
    localparam logic [PTR_W:0]   FillFull = (PTR_W + 1)'(FIFO_DEPTH);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StSat   = 2'd2;
    localparam logic [1:0] StFlush = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [WIDTH-1:0]      count_q, count_d;
    logic                  cur_sym_q, cur_sym_d;
    logic                  sat_eof_q, sat_eof_d;
    logic                  abort_q, abort_d;
    logic [FRAMECNT_W-1:0] frame_runs_q, frame_runs_d;
    logic [FRAMECNT_W-1:0] runs_base;

    logic [WORD_W-1:0]     mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]        fill_q;

    logic                  fifo_full;
    logic                  accept;
    logic                  push;
    logic                  pop;
    logic                  runs_clear;
    logic [WORD_W-1:0]     push_word;

    assign fifo_full = (fill_q == FillFull);
    assign run_valid = (fill_q != '0);
    assign pop       = run_valid && run_ready;
    assign pix_ready = reset_n && ((state_q == StIdle) || (state_q == StRun)) && !fifo_full;
    assign accept    = pix_valid && pix_ready;

    assign {run_len, run_symbol, run_last} = mem_q[rd_ptr_q];
    assign frame_runs  = frame_runs_q;
    assign frame_abort = abort_q;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        cur_sym_d  = cur_sym_q;
        sat_eof_d  = sat_eof_q;
        abort_d    = 1'b0;
        push       = 1'b0;
        push_word  = '0;
        runs_clear = 1'b0;

        if (accept && pix_sof) begin
            // A sof restarts the frame from any accepting state; an open run is dropped.
            abort_d    = (state_q == StRun);
            runs_clear = 1'b1;
            count_d    = WIDTH'(1);
            cur_sym_d  = pix_data;
            if (pix_data) begin
                push      = 1'b1;
                push_word = {{WIDTH{1'b0}}, 1'b0, 1'b0};
            end
            state_d = pix_eof ? StFlush : StRun;
        end else begin
            case (state_q)
                StRun: begin
                    if (accept) begin
                        if (pix_data == cur_sym_q) begin
                            if (count_q != MaxRun) begin
                                count_d = count_q + WIDTH'(1);
                                state_d = pix_eof ? StFlush : StRun;
                            end else begin
                                push      = 1'b1;
                                push_word = {MaxRun, cur_sym_q, 1'b0};
                                count_d   = WIDTH'(1);
                                sat_eof_d = pix_eof;
                                state_d   = StSat;
                            end
                        end else begin
                            push      = 1'b1;
                            push_word = {count_q, cur_sym_q, 1'b0};
                            cur_sym_d = !cur_sym_q;
                            count_d   = WIDTH'(1);
                            state_d   = pix_eof ? StFlush : StRun;
                        end
                    end
                end
                StSat: begin
                    // Zero-length run of the other symbol keeps symbols alternating.
                    if (!fifo_full) begin
                        push      = 1'b1;
                        push_word = {{WIDTH{1'b0}}, !cur_sym_q, 1'b0};
                        state_d   = sat_eof_q ? StFlush : StRun;
                    end
                end
                StFlush: begin
                    if (!fifo_full) begin
                        push      = 1'b1;
                        push_word = {count_q, cur_sym_q, 1'b1};
                        state_d   = StIdle;
                    end
                end
                default: begin
                    // Pixels outside a frame are consumed and dropped.
                end
            endcase
        end
    end

    always_comb begin
        runs_base    = runs_clear ? '0 : frame_runs_q;
        frame_runs_d = runs_base;
        if (push && (runs_base != '1)) begin
            frame_runs_d = runs_base + FRAMECNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            count_q      <= '0;
            cur_sym_q    <= 1'b0;
            sat_eof_q    <= 1'b0;
            abort_q      <= 1'b0;
            frame_runs_q <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            cur_sym_q    <= cur_sym_d;
            sat_eof_q    <= sat_eof_d;
            abort_q      <= abort_d;
            frame_runs_q <= frame_runs_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fill_q <= fill_q + (PTR_W + 1)'(1);
                2'b01:   fill_q <= fill_q - (PTR_W + 1)'(1);
                default: fill_q <= fill_q;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (reset_n && push) begin
            mem_q[wr_ptr_q] <= push_word;
        end
    end

endmodule

// File: tb/tb_rle_mask_encoder.sv
// Bench for rle_mask_encoder: directed frames plus randomized frames checked against
// a run-splitting reference model built from whole-frame pixel lists.
module tb_rle_mask_encoder;

    localparam int unsigned WIDTH      = 4;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned FRAMECNT_W = 16;
    localparam int          MAX_RUN    = (1 << WIDTH) - 1;
    localparam int unsigned WORD_W     = WIDTH + 2;

    typedef logic [WORD_W-1:0] word_t;

    logic                  CLK = 1'b0;
    logic                  reset_n = 1'b0;
    logic                  pix_valid = 1'b0;
    logic                  pix_data = 1'b0;
    logic                  pix_sof = 1'b0;
    logic                  pix_eof = 1'b0;
    logic                  pix_ready;
    logic                  run_valid;
    logic                  run_ready;
    logic [WIDTH-1:0]      run_len;
    logic                  run_symbol;
    logic                  run_last;
    logic [FRAMECNT_W-1:0] frame_runs;
    logic                  frame_abort;

    logic rr_manual = 1'b1;
    logic rr_rand   = 1'b1;
    logic rand_mode = 1'b0;
    assign run_ready = rand_mode ? rr_rand : rr_manual;

    int    errors = 0;
    int    checks = 0;
    word_t obs_q[$];
    word_t exp_q[$];
    bit    cur_pix[$];
    bit    in_frame = 1'b0;
    int    exp_aborts = 0;
    int    abort_cnt = 0;
    int    exp_frame_runs = 0;
    bit    ready_low_en = 1'b0;
    int    ready_low_cnt = 0;

    rle_mask_encoder #(
        .WIDTH      (WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .FRAMECNT_W (FRAMECNT_W)
    ) dut (
        .CLK         (CLK),
        .reset_n     (reset_n),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_data    (pix_data),
        .pix_sof     (pix_sof),
        .pix_eof     (pix_eof),
        .run_valid   (run_valid),
        .run_ready   (run_ready),
        .run_len     (run_len),
        .run_symbol  (run_symbol),
        .run_last    (run_last),
        .frame_runs  (frame_runs),
        .frame_abort (frame_abort)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) rr_rand <= ($urandom_range(0, 3) != 0);

    // Everything observed mid-cycle, where inputs and outputs are settled.
    always @(negedge CLK) begin
        if (reset_n && run_valid && run_ready) obs_q.push_back({run_len, run_symbol, run_last});
        if (frame_abort) abort_cnt++;
        if (ready_low_en && !pix_ready) ready_low_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Encode a whole frame: runs of one symbol, split into MAX_RUN pieces with
    // zero-length runs of the other symbol between them; an aborted frame loses its open run.
    function automatic void model_close(input bit complete);
        word_t w[$];
        bit    exp_sym;
        bit    s;
        int    idx;
        int    len;
        exp_sym = 1'b0;
        idx = 0;
        while (idx < cur_pix.size()) begin
            s = cur_pix[idx];
            len = 0;
            if (s != exp_sym) w.push_back({WIDTH'(0), exp_sym, 1'b0});
            while (idx < cur_pix.size() && cur_pix[idx] == s) begin
                len++;
                idx++;
            end
            while (len > MAX_RUN) begin
                w.push_back({WIDTH'(MAX_RUN), s, 1'b0});
                w.push_back({WIDTH'(0), !s, 1'b0});
                len -= MAX_RUN;
            end
            w.push_back({WIDTH'(len), s, 1'b0});
            exp_sym = !s;
        end
        if (complete) begin
            w[w.size()-1][0] = 1'b1;
            exp_frame_runs = w.size();
        end else begin
            void'(w.pop_back());
        end
        foreach (w[i]) exp_q.push_back(w[i]);
        cur_pix.delete();
    endfunction

    function automatic void model_pix(input bit d, input bit sof, input bit eof);
        if (sof) begin
            if (in_frame) begin
                model_close(1'b0);
                exp_aborts++;
            end
            cur_pix.delete();
            in_frame = 1'b1;
        end
        if (in_frame) begin
            cur_pix.push_back(d);
            if (eof) begin
                model_close(1'b1);
                in_frame = 1'b0;
            end
        end
    endfunction

    function automatic void model_reset();
        in_frame = 1'b0;
        cur_pix.delete();
        exp_q.delete();
        obs_q.delete();
    endfunction

    task automatic send_pix(input bit d, input bit sof, input bit eof);
        int waited;
        waited = 0;
        pix_valid = 1'b1;
        pix_data  = d;
        pix_sof   = sof;
        pix_eof   = eof;
        forever begin
            @(negedge CLK);
            if (pix_ready) break;
            waited++;
            if (waited > 500) break;
        end
        if (waited > 500) begin
            checks++;
            errors++;
            $display("FAIL send_pix: pix_ready stayed 0 for %0d cycles, expected 1", waited);
        end else begin
            @(posedge CLK);
            #1;
            model_pix(d, sof, eof);
        end
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        pix_eof   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (obs_q.size() < exp_q.size() && k < 2000) begin
            @(negedge CLK);
            k++;
        end
        repeat (4) @(negedge CLK);
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        pix_valid = 1'b1;
        pix_sof   = 1'b1;
        pix_data  = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checks++;
        if (pix_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_pix_ready: got %b, expected 0", pix_ready);
        end
        checks++;
        if (run_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_run_valid: got %b, expected 0", run_valid);
        end
        checks++;
        if (frame_runs !== '0 || frame_abort !== 1'b0) begin
            errors++;
            $display("FAIL reset_counters: got frame_runs=%0d abort=%b, expected 0/0",
                     frame_runs, frame_abort);
        end
        @(posedge CLK);
        #1;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        reset_n   = 1'b1;
        @(negedge CLK);
        checks++;
        if (pix_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_pix_ready: got %b, expected 1", pix_ready);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_basic();
        rr_manual = 1'b1;
        send_pix(0, 1, 0); send_pix(0, 0, 0); send_pix(0, 0, 0);
        send_pix(1, 0, 0); send_pix(1, 0, 0); send_pix(0, 0, 1);
        idle(3);
        checks++;
        if (frame_runs !== 16'd3) begin
            errors++;
            $display("FAIL basic_frame_runs_a: got %0d, expected 3", frame_runs);
        end
        send_pix(1, 1, 0); send_pix(1, 0, 1);
        idle(3);
        checks++;
        if (frame_runs !== 16'd2) begin
            errors++;
            $display("FAIL basic_frame_runs_b: got %0d, expected 2", frame_runs);
        end
        send_pix(0, 1, 1);
        wait_drain();
        checks++;
        if (frame_runs !== 16'd1) begin
            errors++;
            $display("FAIL basic_frame_runs_c: got %0d, expected 1", frame_runs);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL basic_count: got %0d words, expected %0d", obs_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL basic_word[%0d]: got %h, expected %h", i, obs_q[i], exp_q[i]);
                end
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_saturation();
        rr_manual = 1'b1;
        ready_low_cnt = 0;
        ready_low_en = 1'b1;
        for (int i = 0; i < 17; i++) send_pix(0, i == 0, i == 16);
        idle(3);
        ready_low_en = 1'b0;
        checks++;
        if (ready_low_cnt != 2) begin
            errors++;
            $display("FAIL sat_ready_low: got %0d low cycles, expected 2", ready_low_cnt);
        end
        wait_drain();
        checks++;
        if (frame_runs !== 16'd3) begin
            errors++;
            $display("FAIL sat_frame_runs: got %0d, expected 3", frame_runs);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL sat_count: got %0d words, expected %0d", obs_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL sat_word[%0d]: got %h, expected %h", i, obs_q[i], exp_q[i]);
                end
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        rr_manual = 1'b0;
        for (int i = 0; i < 5; i++) send_pix(i % 2, i == 0, 0);
        pix_valid = 1'b1;
        pix_data  = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            checks++;
            if (pix_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_pix_ready[%0d]: got %b, expected 0", c, pix_ready);
            end
            checks++;
            if (run_valid !== 1'b1 || {run_len, run_symbol, run_last} !== {WIDTH'(1), 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL bp_head_hold[%0d]: got valid=%b word=%h, expected 1/%h", c,
                         run_valid, {run_len, run_symbol, run_last}, {WIDTH'(1), 1'b0, 1'b0});
            end
        end
        @(posedge CLK);
        #1;
        rr_manual = 1'b1;
        for (int i = 5; i < 11; i++) send_pix(i % 2, 0, i == 10);
        wait_drain();
        checks++;
        if (frame_runs !== 16'd11) begin
            errors++;
            $display("FAIL bp_frame_runs: got %0d, expected 11", frame_runs);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL bp_count: got %0d words, expected %0d", obs_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL bp_word[%0d]: got %h, expected %h", i, obs_q[i], exp_q[i]);
                end
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_abort();
        rr_manual = 1'b1;
        send_pix(1, 0, 0); send_pix(0, 0, 0); send_pix(1, 0, 1);
        idle(3);
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL idle_drop: got %0d words, expected 0", obs_q.size());
        end
        abort_cnt = 0;
        send_pix(0, 1, 0); send_pix(0, 0, 0); send_pix(1, 0, 0);
        send_pix(1, 0, 0); send_pix(1, 0, 0);
        send_pix(1, 1, 0); send_pix(0, 0, 1);
        wait_drain();
        checks++;
        if (abort_cnt != 1) begin
            errors++;
            $display("FAIL abort_pulses: got %0d, expected 1", abort_cnt);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL abort_count: got %0d words, expected %0d", obs_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL abort_word[%0d]: got %h, expected %h", i, obs_q[i], exp_q[i]);
                end
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_midframe();
        rr_manual = 1'b0;
        send_pix(0, 1, 0); send_pix(1, 0, 0); send_pix(0, 0, 0); send_pix(1, 0, 0);
        idle(1);
        reset_n = 1'b0;
        @(negedge CLK);
        checks++;
        if (pix_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_pix_ready: got %b, expected 0", pix_ready);
        end
        @(posedge CLK);
        #1;
        reset_n = 1'b1;
        model_reset();
        @(negedge CLK);
        checks++;
        if (run_valid !== 1'b0 || frame_runs !== '0) begin
            errors++;
            $display("FAIL rst_mid_state: got valid=%b frame_runs=%0d, expected 0/0",
                     run_valid, frame_runs);
        end
        @(posedge CLK);
        #1;
        rr_manual = 1'b1;
        send_pix(0, 1, 0); send_pix(1, 0, 0); send_pix(1, 0, 1);
        wait_drain();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rst_mid_count: got %0d words, expected %0d", obs_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL rst_mid_word[%0d]: got %h, expected %h", i, obs_q[i], exp_q[i]);
                end
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_random();
        int n;
        bit d;
        rand_mode  = 1'b1;
        abort_cnt  = 0;
        exp_aborts = 0;
        for (int f = 0; f < 30; f++) begin
            if ($urandom_range(0, 4) == 0) send_pix($urandom_range(0, 1) == 1, 0, $urandom_range(0, 1) == 1);
            if ($urandom_range(0, 4) == 0) begin
                n = $urandom_range(1, 20);
                d = ($urandom_range(0, 1) == 1);
                for (int i = 0; i < n; i++) begin
                    if ($urandom_range(0, 3) == 0) d = !d;
                    send_pix(d, i == 0, 0);
                end
            end
            n = $urandom_range(1, 40);
            d = ($urandom_range(0, 1) == 1);
            for (int i = 0; i < n; i++) begin
                if (i != 0 && $urandom_range(0, 5) == 0) d = !d;
                send_pix(d, i == 0, i == n - 1);
            end
            wait_drain();
            checks++;
            if (frame_runs !== FRAMECNT_W'(exp_frame_runs)) begin
                errors++;
                $display("FAIL rand_frame_runs[%0d]: got %0d, expected %0d", f, frame_runs, exp_frame_runs);
            end
            checks++;
            if (obs_q.size() != exp_q.size()) begin
                errors++;
                $display("FAIL rand_count[%0d]: got %0d words, expected %0d", f, obs_q.size(), exp_q.size());
            end else begin
                foreach (exp_q[i]) begin
                    checks++;
                    if (obs_q[i] !== exp_q[i]) begin
                        errors++;
                        $display("FAIL rand_word[%0d][%0d]: got %h, expected %h", f, i, obs_q[i], exp_q[i]);
                    end
                end
            end
            obs_q.delete();
            exp_q.delete();
        end
        checks++;
        if (abort_cnt != exp_aborts) begin
            errors++;
            $display("FAIL rand_aborts: got %0d, expected %0d", abort_cnt, exp_aborts);
        end
        rand_mode = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_backpressure();
        test_abort();
        test_reset_midframe();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
